alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (32-bit add `SUM`, equality flag `EQ`) between `NUM_REQ` requesters, for example the PC-increment path, the branch-target path and the load/store address path.
- Round-robin arbitration with a valid/ready handshake per requester.
- Operands are registered before reaching the ALU, and the ALU result is registered back.
- A single response channel is tagged with the requester id.
- Sits between the control/datapath stages and the shared ALU instance.

Parameters:
- `NUM_REQ`, 3, number of requesters (2..4).
- `DATA_WIDTH`, 32, operand and result width; must match the ALU.
- `ID_WIDTH`, `$clog2(NUM_REQ)`, width of the response id (derived; do not override).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; one-hot or zero.
- `req_op1`  in  `NUM_REQ*DATA_WIDTH`  flattened first operands; requester i occupies bits [i*W +: W].
- `req_op2`  in  `NUM_REQ*DATA_WIDTH`  flattened second operands.
- `req_lock`  in  `NUM_REQ`  hold-grant request; present only with `ALU_ARB_LOCK_EN`.
- `alu_op1`  out  `DATA_WIDTH`  to ALU `ALUop1`.
- `alu_op2`  out  `DATA_WIDTH`  to ALU `ALUop2`.
- `alu_sum`  in  `DATA_WIDTH`  from ALU `SUM`.
- `alu_eq`  in  1  from ALU `EQ`.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_id`  out  `ID_WIDTH`  index of the requester that owns the response.
- `resp_sum`  out  `DATA_WIDTH`  registered sum.
- `resp_eq`  out  1  registered equality flag.

Behaviour:
- **FSM states:** `IDLE`, `ISSUE`, `RESP`.
- **Reset:** `rst_n` low forces the following, asynchronously:
  - state = `IDLE`;
  - `resp_valid` = `resp_id` = `resp_sum` = `resp_eq` = 0;
  - operand registers = 0, so `alu_op1` = `alu_op2` = 0;
  - `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
- **Reset mid-operation:** the in-flight op is dropped and no response is produced.
- **Grant:**
  - Computed combinationally in `IDLE`, and in `RESP` when `resp_ready` = 1.
  - Winner = first i with `req_valid[i]`, searching from `last_grant+1` modulo `NUM_REQ`.
  - `req_ready[winner]` = 1 in that cycle only. The handshake fires on `req_valid & req_ready`.
  - `req_ready` = 0 in `ISSUE`, and in `RESP` while `resp_ready` = 0.
- **Accept:**
  - Capture the winner's `op1`/`op2` into the operand registers and its index into the id register.
  - Set `last_grant` = winner and go to `ISSUE`.
- **`ISSUE`** (exactly 1 cycle):
  - `alu_op1`/`alu_op2` are driven from the operand registers.
  - At the cycle end, capture `alu_sum`/`alu_eq` into the response registers, then go to `RESP`.
- **`RESP`:**
  - `resp_valid` = 1; `resp_*` are stable until `resp_ready`.
  - On `resp_ready`: go to `ISSUE` if a new request is accepted in the same cycle, else go to `IDLE`.
- **Latency and throughput:**
  - Accept at cycle T gives `resp_valid` at T+2.
  - Sustained throughput is 1 op per 2 cycles with `resp_ready` held high.
- **Arithmetic:** the sum wraps modulo 2^`DATA_WIDTH`; there is no carry or overflow output.
- **Sampling:** a requester dropping `req_valid` without a handshake is legal; it is simply not granted. Operands are sampled only at the handshake.
- **No valid requests:** `req_ready` = 0 and `last_grant` is unchanged.
- **`alu_op1`/`alu_op2` outside `ISSUE`:** hold their last registered values; there is no toggling.

Optional Feature:
- Macro: `ALU_ARB_LOCK_EN`.
- **With the macro:**
  - The `req_lock` port exists.
  - If the granted requester has `req_lock` = 1 at its handshake, a lock flag is set.
  - While the lock is set, only that requester is eligible and `last_grant` is not advanced.
  - The lock clears at that requester's next handshake with `req_lock` = 0, or when `req_valid` of the locked requester is low in a grant cycle.
- **Without the macro:** the port is absent and plain round-robin applies.

Decomposition:
- **Package `alu_arb_pkg`:**
  - `arb_state_e` (`IDLE`, `ISSUE`, `RESP`);
  - `ALU_DATA_WIDTH` = 32;
  - `ALU_MAX_REQ` = 4.
- **Sub-module `rr_grant`:**
  - Pure combinational round-robin picker.
  - Inputs: request vector, `last_grant`, mask.
  - Outputs: one-hot grant and encoded index.
  - Unit-testable standalone.

Test Plan:
1. **Reset:** assert `rst_n` = 0 mid-`RESP` with `resp_valid` = 1 -> `resp_valid` drops to 0 immediately (asynchronously), the FSM is in `IDLE` after release, and no stale response appears.
2. **Single request:** req0 `op1` = 0x0000_0005, `op2` = 0x0000_0007, `resp_ready` = 1 -> `req_ready[0]` at T; at T+2 `resp_valid` = 1, `resp_id` = 0, `resp_sum` = 0x0000_000C, `resp_eq` = 0.
3. **Equality and wrap:** req1 `op1` = 0xFFFF_FFFF, `op2` = 0xFFFF_FFFF -> `resp_sum` = 0xFFFF_FFFE, `resp_eq` = 1, `resp_id` = 1.
4. **Round-robin:** all 3 requesters continuously valid, `resp_ready` = 1 -> grant order is 0,1,2,0,1,2 with handshakes every 2 cycles and no starvation.
5. **Backpressure:** `resp_ready` = 0 for 5 cycles in `RESP` -> `resp_*` stay stable, all `req_ready` = 0, and no new accept occurs until `resp_ready` = 1.
6. **Lock (`ALU_ARB_LOCK_EN`):** req2 holds `req_lock` = 1 for 3 ops while req0/req1 are valid -> 3 consecutive grants to req2, then req0 is granted next.

Source files
------------

// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Brief    : Shared types and constants for the shared-ALU arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

  // Width of the shared ALU datapath.
  localparam int ALU_DATA_WIDTH = 32;
  // Largest supported number of requesters.
  localparam int ALU_MAX_REQ    = 4;

  // Arbiter FSM: wait for a request, drive the ALU, hold the response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant
// Brief    : Combinational round-robin picker. Searches eligible requests
//            (request & mask) starting one past the previous winner, wrapping
//            modulo NUM_REQ, and returns a one-hot grant plus encoded index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant #(
  parameter int NUM_REQ  = 3,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_last_grant,
  input  logic [NUM_REQ-1:0]  i_mask,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_grant_idx
);

  // NUM_REQ at the width of the wrap arithmetic (one bit wider than an id).
  localparam logic [ID_WIDTH:0] c_num_req = NUM_REQ[ID_WIDTH:0];

  logic [NUM_REQ-1:0] w_eligible;
  logic [ID_WIDTH:0]  w_sum;
  logic [ID_WIDTH-1:0] w_idx;
  logic               w_found;

  assign w_eligible = i_req & i_mask;

  // Walk last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first eligible hit wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // last_grant < NUM_REQ and k <= NUM_REQ, so one subtraction wraps it.
      w_sum = {1'b0, i_last_grant} + k[ID_WIDTH:0];
      if (w_sum >= c_num_req) begin
        w_sum = w_sum - c_num_req;
      end
      w_idx = w_sum[ID_WIDTH-1:0];
      if (!w_found && w_eligible[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Shares one combinational ALU (add + equality) between NUM_REQ
//            requesters with round-robin valid/ready arbitration. Operands are
//            registered into the ALU, the result is registered back and
//            returned on a single id-tagged response channel.
//            Optional grant lock enabled by macro ALU_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [DATA_WIDTH-1:0]         alu_op1,
  output logic [DATA_WIDTH-1:0]         alu_op2,
  input  logic [DATA_WIDTH-1:0]         alu_sum,
  input  logic                          alu_eq,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_sum,
  output logic                          resp_eq
);

  // After reset the search starts at NUM_REQ-1 + 1, so requester 0 wins first.
  localparam logic [ID_WIDTH-1:0] c_last_rst = ID_WIDTH'(NUM_REQ - 1);

  arb_state_e           r_state;
  arb_state_e           w_state_next;
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic [DATA_WIDTH-1:0] r_resp_sum;
  logic                  r_resp_eq;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ID_WIDTH-1:0]   r_last_grant;
  logic [DATA_WIDTH-1:0] w_sel_op1;
  logic [DATA_WIDTH-1:0] w_sel_op2;
  logic [NUM_REQ-1:0]    w_grant;
  logic [NUM_REQ-1:0]    w_mask;
  logic [ID_WIDTH-1:0]   w_grant_idx;
  logic                  w_any;
  logic                  w_window;
  logic                  w_accept;
  logic                  w_lock_active;

  // A grant is offered when idle, or when the current response retires now.
  assign w_window  = (r_state == IDLE) || ((r_state == RESP) && resp_ready);
  assign w_any     = |w_grant;
  assign w_accept  = w_window && w_any;
  assign req_ready = w_window ? w_grant : '0;

  rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_grant (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .i_mask       (w_mask),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

`ifdef ALU_ARB_LOCK_EN
  logic                r_lock;
  logic [ID_WIDTH-1:0] r_lock_id;

  // The lock only holds while its owner keeps requesting; a dropped valid
  // releases it in that same grant cycle so the others can win immediately.
  assign w_lock_active = r_lock && req_valid[r_lock_id];

  // Restrict eligibility to the lock owner while the lock is active.
  always_comb begin
    w_mask = '1;
    if (w_lock_active) begin
      w_mask            = '0;
      w_mask[r_lock_id] = 1'b1;
    end
  end

  // Lock flag follows req_lock at each handshake; released on owner idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (w_accept) begin
      r_lock    <= req_lock[w_grant_idx];
      r_lock_id <= w_grant_idx;
    end else if (w_window && r_lock && !req_valid[r_lock_id]) begin
      r_lock    <= 1'b0;
    end
  end
`else
  assign w_lock_active = 1'b0;
  assign w_mask        = '1;
`endif

  // One-hot operand select of the current winner.
  always_comb begin
    w_sel_op1 = '0;
    w_sel_op2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_op1 = req_op1[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_op2 = req_op2[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: ISSUE lasts one cycle, RESP holds until resp_ready.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = ISSUE;
      ISSUE:   w_state_next = RESP;
      RESP:    if (resp_ready) w_state_next = w_accept ? ISSUE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand/id capture at the handshake; ALU result capture at end of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1        <= '0;
      r_op2        <= '0;
      r_id         <= '0;
      r_last_grant <= c_last_rst;
      r_resp_sum   <= '0;
      r_resp_eq    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op1 <= w_sel_op1;
        r_op2 <= w_sel_op2;
        r_id  <= w_grant_idx;
        // Locked re-grants leave the round-robin pointer where it was.
        if (!w_lock_active) begin
          r_last_grant <= w_grant_idx;
        end
      end
      if (r_state == ISSUE) begin
        r_resp_sum <= alu_sum;
        r_resp_eq  <= alu_eq;
      end
    end
  end

  assign alu_op1    = r_op1;
  assign alu_op2    = r_op2;
  assign resp_valid = (r_state == RESP);
  assign resp_id    = r_id;
  assign resp_sum   = r_resp_sum;
  assign resp_eq    = r_resp_eq;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed self-checking bench for alu_share_arbiter (NUM_REQ=3,
//            DATA_WIDTH=32) with a behavioural ALU attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_op1;
  logic [N*W-1:0] req_op2;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif
  logic [W-1:0]   alu_op1;
  logic [W-1:0]   alu_op2;
  logic [W-1:0]   alu_sum;
  logic           alu_eq;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_sum;
  logic           resp_eq;

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
`ifdef ALU_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_sum    (alu_sum),
    .alu_eq     (alu_eq),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_eq    (resp_eq)
  );

  // Behavioural shared ALU.
  assign alu_sum = alu_op1 + alu_op2;
  assign alu_eq  = (alu_op1 == alu_op2);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op1[i*W +: W] = a;
    req_op2[i*W +: W] = b;
  endtask

  logic [N-1:0] exp_onehot;
  int           exp_id;

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_op1    = '0;
    req_op2    = '0;
    resp_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    req_lock   = '0;
`endif
    tick();
    tick();
    // Reset state.
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_sum", resp_sum, 0);
    chk("rst_resp_eq", resp_eq, 0);
    chk("rst_alu_op1", alu_op1, 0);
    chk("rst_alu_op2", alu_op2, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_no_req_ready", req_ready, 0);

    // Single request from requester 0: 5 + 7.
    tick();
    set_ops(0, 32'h0000_0005, 32'h0000_0007);
    req_valid  = 3'b001;
    resp_ready = 1'b1;
    #1;
    chk("single_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    #1;
    chk("single_issue_ready", req_ready, 0);
    chk("single_issue_valid", resp_valid, 0);
    chk("single_alu_op1", alu_op1, 32'h5);
    chk("single_alu_op2", alu_op2, 32'h7);
    tick();
    chk("single_resp_valid", resp_valid, 1);
    chk("single_resp_id", resp_id, 0);
    chk("single_resp_sum", resp_sum, 32'h0000_000C);
    chk("single_resp_eq", resp_eq, 0);
    tick();
    chk("single_back_idle", resp_valid, 0);

    // Equality and wrap from requester 1, then backpressure in RESP.
    set_ops(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid  = 3'b010;
    resp_ready = 1'b0;
    #1;
    chk("eq_ready", req_ready, 3'b010);
    tick();
    req_valid = 3'b001;
    set_ops(0, 32'h0000_0100, 32'h0000_0023);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_id", resp_id, 1);
      chk("bp_resp_sum", resp_sum, 32'hFFFF_FFFE);
      chk("bp_resp_eq", resp_eq, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_alu_op1_hold", alu_op1, 32'hFFFF_FFFF);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    #1;
    chk("bp_next_alu_op1", alu_op1, 32'h100);
    tick();
    chk("bp_next_resp_id", resp_id, 0);
    chk("bp_next_resp_sum", resp_sum, 32'h0000_0123);
    chk("bp_next_resp_eq", resp_eq, 0);
    tick();

    // Asynchronous reset while holding a response.
    set_ops(2, 32'h0000_0040, 32'h0000_0002);
    req_valid  = 3'b100;
    resp_ready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    chk("mid_resp_valid", resp_valid, 1);
    chk("mid_resp_sum", resp_sum, 32'h42);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", resp_valid, 0);
    chk("async_rst_sum", resp_sum, 0);
    chk("async_rst_alu_op1", alu_op1, 0);
    tick();
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_no_resp", resp_valid, 0);
      chk("post_rst_no_ready", req_ready, 0);
    end

    // Round-robin with all requesters valid: 0,1,2,0,1,2.
    for (int i = 0; i < N; i++) begin
      set_ops(i, 32'h10 * (i + 1), i);
    end
    req_valid = 3'b111;
    #1;
    for (int j = 0; j < 6; j++) begin
      exp_id     = j % 3;
      exp_onehot = 3'b001 << exp_id;
      chk("rr_grant", req_ready, exp_onehot);
      tick();
      chk("rr_issue_ready", req_ready, 0);
      tick();
      chk("rr_resp_valid", resp_valid, 1);
      chk("rr_resp_id", resp_id, exp_id);
      chk("rr_resp_sum", resp_sum, (exp_id == 0) ? 32'h10 : (exp_id == 1) ? 32'h21 : 32'h32);
    end
    req_valid = '0;
    tick();
    chk("rr_done_idle", resp_valid, 0);

`ifdef ALU_ARB_LOCK_EN
    // Requester 2 locks for three ops while 0 and 1 also request.
    req_valid = 3'b100;
    req_lock  = 3'b100;
    #1;
    chk("lock_first_grant", req_ready, 3'b100);
    tick();
    req_valid = 3'b111;
    tick();
    chk("lock_resp1_id", resp_id, 2);
    chk("lock_grant2", req_ready, 3'b100);
    tick();
    tick();
    chk("lock_resp2_id", resp_id, 2);
    chk("lock_grant3", req_ready, 3'b100);
    tick();
    req_valid = 3'b011;
    req_lock  = '0;
    tick();
    chk("lock_resp3_id", resp_id, 2);
    chk("lock_release_grant", req_ready, 3'b001);
    tick();
    req_valid = '0;
    tick();
    chk("lock_after_id", resp_id, 0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
